// File: rtl/keymem_pro.sv
// keymem_pro: AES round-key store with two independent stalling request/response read ports.
// Optional build macro KEYMEM_FWD_EN: forward a same-cycle write directly to a port waiting on it.
`timescale 1ns/1ps

module keymem_pro_rd_port #(
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 4,
    parameter int NK_W   = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [NK_W-1:0]   i_nk,
    input  logic              i_hit,
    input  logic [KEY_W-1:0]  i_rdata,
    input  logic              i_fwd,
    input  logic [KEY_W-1:0]  i_fwd_key,
    output logic [ADDR_W-1:0] o_raddr,
    output logic              o_busy,
    output logic              o_valid,
    output logic              o_err,
    output logic [KEY_W-1:0]  o_key
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic [KEY_W-1:0]  r_key;
    logic              w_active;
    logic              w_oor;

    // While idle the incoming address is looked up so a hit answers next cycle.
    assign o_raddr  = (r_state == S_IDLE) ? i_addr : r_addr;
    assign w_active = ((r_state == S_IDLE) && i_req) || (r_state == S_WAIT);
    assign w_oor    = NK_W'(o_raddr) >= i_nk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_key   <= '0;
        end else begin
            // NOTE: err/key default to zero every cycle so they are only non-zero in RESP.
            r_err <= 1'b0;
            r_key <= '0;
            if ((r_state == S_IDLE) && i_req) begin
                r_addr <= i_addr;
            end
            if (r_state == S_RESP) begin
                r_state <= S_IDLE;
            end else if (w_active) begin
                if (w_oor) begin
                    r_state <= S_RESP;
                    r_err   <= 1'b1;
                end else if (i_fwd) begin
                    r_state <= S_RESP;
                    r_key   <= i_fwd_key;
                end else if (i_hit) begin
                    r_state <= S_RESP;
                    r_key   <= i_rdata;
                end else begin
                    r_state <= S_WAIT;
                end
            end
        end
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_valid = (r_state == S_RESP);
    assign o_err   = r_err;
    assign o_key   = r_key;
endmodule

module keymem_pro #(
    parameter int KEY_W  = 128,
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inval,
    input  logic [1:0]        mode,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [KEY_W-1:0]  wkey,
    output logic              wr_err,
    output logic [DEPTH-1:0]  valid_bits,
    output logic              sched_done,
    input  logic              rd_encr_req,
    input  logic [ADDR_W-1:0] rd_encr_addr,
    output logic              rd_encr_busy,
    output logic              rd_encr_valid,
    output logic              rd_encr_err,
    output logic [KEY_W-1:0]  rd_encr_key,
    input  logic              rd_decr_req,
    input  logic [ADDR_W-1:0] rd_decr_addr,
    output logic              rd_decr_busy,
    output logic              rd_decr_valid,
    output logic              rd_decr_err,
    output logic [KEY_W-1:0]  rd_decr_key
);
    localparam int NK_W = ADDR_W + 1;

    logic [NK_W-1:0]   r_nk;
    logic [KEY_W-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic              r_wr_err;
    logic              w_in_range;
    logic              w_wr_ok;
    logic              w_wr_drop;
    logic [NK_W-1:0]   w_new_nk;
    logic              w_sched_done;
    logic [ADDR_W-1:0] w_raddr_e, w_raddr_d;
    logic              w_hit_e, w_hit_d;
    logic              w_fwd_e, w_fwd_d;
    logic [KEY_W-1:0]  w_rdata_e, w_rdata_d;

    // Writes are judged against the NK in force before any same-cycle invalidate.
    assign w_in_range = NK_W'(waddr) < r_nk;
    assign w_wr_ok    = w_en && w_in_range && (!inval || (waddr == '0));
    assign w_wr_drop  = w_en && !w_in_range && !inval;

    always_comb begin
        case (mode)
            2'd0:    w_new_nk = NK_W'(11);
            2'd1:    w_new_nk = NK_W'(13);
            default: w_new_nk = NK_W'(15);
        endcase
    end

    // NOTE: the key array has no reset; every read is qualified by valid_bits instead.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[waddr] <= wkey;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nk     <= NK_W'(11);
            r_valid  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_drop;
            if (inval) begin
                r_nk    <= w_new_nk;
                r_valid <= {{(DEPTH-1){1'b0}}, r_valid[0] | w_wr_ok};
            end else if (w_wr_ok) begin
                r_valid[waddr] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_sched_done = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(r_nk)) && !r_valid[i]) begin
                w_sched_done = 1'b0;
            end
        end
    end

    always_comb begin
        w_hit_e   = 1'b0;
        w_rdata_e = '0;
        w_hit_d   = 1'b0;
        w_rdata_d = '0;
        if (int'(w_raddr_e) < DEPTH) begin
            w_hit_e   = r_valid[w_raddr_e];
            w_rdata_e = r_mem[w_raddr_e];
        end
        if (int'(w_raddr_d) < DEPTH) begin
            w_hit_d   = r_valid[w_raddr_d];
            w_rdata_d = r_mem[w_raddr_d];
        end
    end

`ifdef KEYMEM_FWD_EN
    assign w_fwd_e = w_wr_ok && (waddr == w_raddr_e);
    assign w_fwd_d = w_wr_ok && (waddr == w_raddr_d);
`else
    assign w_fwd_e = 1'b0;
    assign w_fwd_d = 1'b0;
`endif

    keymem_pro_rd_port #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .NK_W(NK_W)) u_encr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (rd_encr_req),
        .i_addr    (rd_encr_addr),
        .i_nk      (r_nk),
        .i_hit     (w_hit_e),
        .i_rdata   (w_rdata_e),
        .i_fwd     (w_fwd_e),
        .i_fwd_key (wkey),
        .o_raddr   (w_raddr_e),
        .o_busy    (rd_encr_busy),
        .o_valid   (rd_encr_valid),
        .o_err     (rd_encr_err),
        .o_key     (rd_encr_key)
    );

    keymem_pro_rd_port #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .NK_W(NK_W)) u_decr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (rd_decr_req),
        .i_addr    (rd_decr_addr),
        .i_nk      (r_nk),
        .i_hit     (w_hit_d),
        .i_rdata   (w_rdata_d),
        .i_fwd     (w_fwd_d),
        .i_fwd_key (wkey),
        .o_raddr   (w_raddr_d),
        .o_busy    (rd_decr_busy),
        .o_valid   (rd_decr_valid),
        .o_err     (rd_decr_err),
        .o_key     (rd_decr_key)
    );

    assign wr_err     = r_wr_err;
    assign valid_bits = r_valid;
    assign sched_done = w_sched_done;
endmodule
